// File: rtl/wb_ram_banked_if.sv
// Wishbone-style request/response bundle for the banked data RAM.
interface wb_ram_banked_if #(
  parameter int ADDR_W = 32
);
  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        width;
  logic [31:0]       data_write;
  logic [31:0]       data_read;
  logic              ack;
  logic              err;
  logic              ready;

  modport master (
    output cyc, stb, we, addr, width, data_write,
    input  data_read, ack, err, ready
  );

  modport slave (
    input  cyc, stb, we, addr, width, data_write,
    output data_read, ack, err, ready
  );
endinterface

// File: rtl/wb_ram_banked.sv
// Wishbone-slave byte-lane RAM with programmable response latency,
// alignment/range error response and an optional post-reset zeroing sweep.
module wb_ram_banked #(
  parameter int SIZE      = 4096,
  parameter int ADDR_W    = 32,
  parameter int LATENCY   = 1,
  parameter int CLEAR_RST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_ram_banked_if.slave    bus
);
  localparam int DEPTH = SIZE / 4;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   clr_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [1:0]         lane_reg;
  logic [1:0]         width_reg;
  logic               we_reg;
  logic               bad_reg;
  logic [3:0]         be_reg;
  logic [31:0]        wdata_reg;
  logic [CNT_W-1:0]   wait_reg;
  logic               ack_reg;
  logic               err_reg;
  logic               ready_reg;
  logic               rd_valid_reg;

  // Decode of the request currently on the bus (only consumed in IDLE)
  logic [IDX_W-1:0]   req_idx;
  logic [1:0]         req_lane;
  logic               req_bad;
  logic [3:0]         req_be;
  logic [31:0]        req_wdata;

  assign req_idx   = bus.addr[IDX_W+1:2];
  assign req_lane  = bus.addr[1:0];
  assign req_wdata = bus.data_write << {req_lane, 3'b000};
  assign req_bad   = (bus.width == 2'b11)
                   | ((bus.width == 2'b01) & bus.addr[0])
                   | ((bus.width == 2'b10) & (|bus.addr[1:0]))
                   | (bus.addr >= ADDR_W'(SIZE));

  always_comb begin
    req_be = 4'b1111;
    case (bus.width)
      2'b00:   req_be = 4'b0001 << req_lane;
      2'b01:   req_be = 4'b0011 << req_lane;
      default: req_be = 4'b1111;
    endcase
  end

  logic             start;
  logic             go_resp;
  logic             bad_now;
  logic             we_now;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_en;

  assign start   = (state_reg == IDLE) && bus.cyc && bus.stb;
  assign go_resp = (start && (LATENCY == 1))
                 || ((state_reg == WAIT) && bus.cyc && (wait_reg == '0));
  assign bad_now = (state_reg == IDLE) ? req_bad : bad_reg;
  assign we_now  = (state_reg == IDLE) ? bus.we : we_reg;
  assign rd_idx  = (state_reg == IDLE) ? req_idx : idx_reg;
  assign rd_en   = go_resp && !bad_now && !we_now;

  // Write port: zero sweep in CLEAR, otherwise commit on leaving an acked RESP
  logic             clear_we;
  logic             commit;
  logic [IDX_W-1:0] waddr;
  logic [31:0]      wdata_m;
  logic [3:0]       lane_we;
  logic [31:0]      rd_word;

  assign clear_we = (state_reg == CLEAR);
  assign commit   = (state_reg == RESP) && ack_reg && we_reg;
  assign waddr    = clear_we ? clr_reg : idx_reg;
  assign wdata_m  = clear_we ? 32'd0 : wdata_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [0:DEPTH-1];
      logic [7:0] rd_reg;

      assign lane_we[gi] = clear_we | (commit & be_reg[gi]);

      always_ff @(posedge clk) begin
        if (lane_we[gi]) begin
          mem[waddr] <= wdata_m[gi*8 +: 8];
        end
        if (rd_en) begin
          rd_reg <= mem[rd_idx];
        end
      end

      assign rd_word[gi*8 +: 8] = rd_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= (CLEAR_RST != 0) ? CLEAR : IDLE;
      clr_reg      <= '0;
      idx_reg      <= '0;
      lane_reg     <= '0;
      width_reg    <= '0;
      we_reg       <= 1'b0;
      bad_reg      <= 1'b0;
      be_reg       <= '0;
      wdata_reg    <= '0;
      wait_reg     <= '0;
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
      ready_reg    <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
      rd_valid_reg <= 1'b0;
      if (go_resp) begin
        ack_reg      <= !bad_now;
        err_reg      <= bad_now;
        rd_valid_reg <= rd_en;
      end
      case (state_reg)
        CLEAR: begin
          clr_reg <= clr_reg + 1'b1;
          if (clr_reg == IDX_W'(DEPTH - 1)) begin
            state_reg <= IDLE;
            ready_reg <= 1'b1;
          end
        end
        IDLE: begin
          ready_reg <= 1'b1;
          if (start) begin
            idx_reg   <= req_idx;
            lane_reg  <= req_lane;
            width_reg <= bus.width;
            we_reg    <= bus.we;
            bad_reg   <= req_bad;
            be_reg    <= req_be;
            wdata_reg <= req_wdata;
            wait_reg  <= CNT_W'(LATENCY - 2);
            state_reg <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!bus.cyc) begin
            state_reg <= IDLE;
          end else if (wait_reg == '0) begin
            state_reg <= RESP;
          end else begin
            wait_reg <= wait_reg - 1'b1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Read formatting works only from registered state, so no input reaches data_read
  logic [31:0] rd_shift;
  logic [31:0] rd_fmt;

  assign rd_shift = rd_word >> {lane_reg, 3'b000};

  always_comb begin
    rd_fmt = rd_shift;
    case (width_reg)
      2'b00:   rd_fmt = {24'd0, rd_shift[7:0]};
      2'b01:   rd_fmt = {16'd0, rd_shift[15:0]};
      default: rd_fmt = rd_shift;
    endcase
  end

  assign bus.data_read = rd_valid_reg ? rd_fmt : 32'd0;
  assign bus.ack       = ack_reg;
  assign bus.err       = err_reg;
  assign bus.ready     = ready_reg;
endmodule
